// File: rtl/bitop_pkg.sv
// Shared op codes, FSM state type and width helper for the flag-datapath scheduler.
package bitop_pkg;

    localparam logic [2:0] OP_OR   = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_MUX  = 3'd3;
    localparam logic [2:0] OP_ANDR = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_INV  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/bitop_sched_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping around.
module rr_arbiter
    import bitop_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic found;

    // Two passes (ptr..NREQ-1, then 0..ptr-1) avoid a modulo on the index.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[k] && k >= 32'(ptr)) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req[k] && k < 32'(ptr)) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = PW'(k);
            end
        end
    end

endmodule

// File: rtl/bitop_sched.sv
// Round-robin scheduler executing single-bit logic ops on a shared flag register file.
module bitop_sched
    import bitop_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned REGS = 8,
    localparam int unsigned IDX_W = clog2(REGS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_i,
    input  logic [3*NREQ-1:0]     op_i,
    input  logic [IDX_W*NREQ-1:0] a_i,
    input  logic [IDX_W*NREQ-1:0] b_i,
    input  logic [IDX_W*NREQ-1:0] c_i,
    input  logic [IDX_W*NREQ-1:0] dst_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  err_o,
    output logic [REGS-1:0]       flags_o
);

    localparam int unsigned PW = clog2(NREQ);

    state_t state_q, state_nx;
    logic capture, exec_en, wb_en;

    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   win_idx;

    logic [2:0]       sel_op, op_q;
    logic [IDX_W-1:0] sel_a, sel_b, sel_c, sel_dst;
    logic [IDX_W-1:0] a_q, b_q, c_q, dst_q;
    logic             andr, reject, res_q, rej_q;

    function automatic logic logic_unit(input logic [2:0] op, input logic fa, input logic fb,
                                        input logic fc, input logic fr);
        case (op)
            OP_OR:   return fa | fb;
            OP_NOT:  return ~fa;
            OP_EQ:   return fa ~^ fb;
            OP_MUX:  return fa ? fb : fc;
            OP_ANDR: return fr;
            OP_AND:  return fa & fb;
            default: return 1'b0;
        endcase
    endfunction

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (win_oh),
        .idx (win_idx)
    );

    always_comb begin
        sel_op  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_c   = '0;
        sel_dst = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (win_oh[k]) begin
                sel_op  = op_i[3*k +: 3];
                sel_a   = a_i[IDX_W*k +: IDX_W];
                sel_b   = b_i[IDX_W*k +: IDX_W];
                sel_c   = c_i[IDX_W*k +: IDX_W];
                sel_dst = dst_i[IDX_W*k +: IDX_W];
            end
        end
    end

    always_comb begin
        andr = 1'b1;
        for (int unsigned i = 0; i < REGS; i++) begin
            if (i >= 32'(a_q) && i <= 32'(b_q)) andr = andr & flags_o[i];
        end
        reject = (op_q == OP_INV) || (op_q == OP_ANDR && b_q < a_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        capture  = 1'b0;
        exec_en  = 1'b0;
        wb_en    = 1'b0;
        case (state_q)
            IDLE: if (|req_i) begin
                capture  = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                exec_en  = 1'b1;
                state_nx = WB;
            end
            WB: begin
                wb_en    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_o <= '0;
            gnt_o   <= '0;
            done_o  <= '0;
            err_o   <= 1'b0;
            ptr_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            dst_q   <= '0;
            res_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            done_o <= '0;
            err_o  <= 1'b0;
            if (capture) begin
                gnt_o <= win_oh;
                ptr_q <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                c_q   <= sel_c;
                dst_q <= sel_dst;
            end
            if (exec_en) begin
                res_q <= logic_unit(op_q, flags_o[a_q], flags_o[b_q], flags_o[c_q], andr);
                rej_q <= reject;
            end
            if (wb_en) begin
                if (!rej_q) flags_o[dst_q] <= res_q;
                done_o <= gnt_o;
                err_o  <= rej_q;
                gnt_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bitop_sched.sv
// Self-checking bench for bitop_sched: directed scenarios plus randomized commands against a flag/pointer model.
module tb_bitop_sched;
    import bitop_pkg::*;

    localparam int NREQ = 4;
    localparam int REGS = 8;
    localparam int IW   = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_i;
    logic [3*NREQ-1:0]    op_i;
    logic [IW*NREQ-1:0]   a_i, b_i, c_i, dst_i;
    logic [NREQ-1:0]      gnt_o, done_o;
    logic                 err_o;
    logic [REGS-1:0]      flags_o;

    always #5 CLK = ~CLK;

    bitop_sched #(.NREQ(NREQ), .REGS(REGS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req_i   (req_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .dst_i   (dst_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .flags_o (flags_o)
    );

    int tests = 0;
    int fails = 0;

    logic [2:0] c_op  [NREQ];
    logic [2:0] c_a   [NREQ];
    logic [2:0] c_b   [NREQ];
    logic [2:0] c_c   [NREQ];
    logic [2:0] c_dst [NREQ];

    logic [7:0] mflags;
    int         mptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            op_i[3*k +: 3]    = c_op[k];
            a_i[IW*k +: IW]   = c_a[k];
            b_i[IW*k +: IW]   = c_b[k];
            c_i[IW*k +: IW]   = c_c[k];
            dst_i[IW*k +: IW] = c_dst[k];
        end
    endtask

    task automatic set_cmd(input int k, input logic [2:0] op, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
        c_op[k] = op; c_a[k] = a; c_b[k] = b; c_c[k] = c; c_dst[k] = d;
        drive();
    endtask

    // Winner = first requesting index scanning cyclically from the pointer.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int s = 0; s < NREQ; s++)
            if (r[(p + s) % NREQ]) return (p + s) % NREQ;
        return -1;
    endfunction

    // Returns {rejected, result} computed from the op table.
    function automatic logic [1:0] model(input logic [7:0] f, input logic [2:0] op,
                                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        int ia, ib;
        logic [7:0] m;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0: return {1'b0, f[a] | f[b]};
            3'd1: return {1'b0, !f[a]};
            3'd2: return {1'b0, f[a] == f[b]};
            3'd3: return {1'b0, f[a] ? f[b] : f[c]};
            3'd4: begin
                if (ib < ia) return 2'b10;
                m = 8'((1 << (ib - ia + 1)) - 1);
                return {1'b0, ((f >> ia) & m) == m};
            end
            3'd5: return 2'b00;
            3'd6: return {1'b0, f[a] & f[b]};
            default: return 2'b10;
        endcase
    endfunction

    task automatic service(input bit drop, input bit perturb, output int w, output int waited,
                           output logic got_err);
        logic [NREQ-1:0] r;
        logic [2:0] op, a, b, c, d;
        logic [1:0] exp;
        waited  = 0;
        w       = -1;
        got_err = 1'b0;
        r       = '0;
        while (gnt_o == '0 && waited < 12) begin
            r = req_i;
            tick();
            waited++;
        end
        if (gnt_o == '0) begin
            check("grant_timeout", 32'(gnt_o), 32'(1));
            return;
        end
        w = pick(r, mptr);
        if (w < 0) begin
            check("grant_without_req", 32'(gnt_o), 32'(0));
            return;
        end
        check("gnt_after_edge0", 32'(gnt_o), 32'(1 << w));
        op = c_op[w]; a = c_a[w]; b = c_b[w]; c = c_c[w]; d = c_dst[w];
        exp = model(mflags, op, a, b, c);
        if (perturb) begin
            c_op[w] = ~c_op[w];
            c_a[w]  = c_a[w] + 3'd1;
            drive();
            req_i[w] = 1'b0;
        end
        tick();
        check("gnt_held_exec", 32'(gnt_o), 32'(1 << w));
        check("no_done_exec", 32'(done_o), 32'(0));
        tick();
        if (!exp[1]) mflags[d] = exp[0];
        mptr = (w + 1) % NREQ;
        got_err = err_o;
        check("flags_wb", 32'(flags_o), 32'(mflags));
        check("done_wb", 32'(done_o), 32'(1 << w));
        check("err_wb", 32'(err_o), 32'(exp[1]));
        check("gnt_clear_wb", 32'(gnt_o), 32'(0));
        if (drop) req_i[w] = 1'b0;
    endtask

    task automatic set_flags(input logic [7:0] p);
        int w, wt;
        logic e;
        for (int j = 0; j < 8; j++) begin
            set_cmd(0, OP_CLR, 3'd0, 3'd0, 3'd0, 3'(j));
            req_i[0] = 1'b1;
            service(1'b1, 1'b0, w, wt, e);
            if (p[j]) begin
                set_cmd(0, OP_NOT, 3'(j), 3'd0, 3'd0, 3'(j));
                req_i[0] = 1'b1;
                service(1'b1, 1'b0, w, wt, e);
            end
        end
        check("set_flags", 32'(flags_o), 32'(p));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   w, wt, n;
        logic e;
        logic [2:0] seq [5];

        RST   = 1'b1;
        req_i = '0;
        for (int k = 0; k < NREQ; k++) set_cmd(k, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        mflags = '0;
        mptr   = 0;
        repeat (3) tick();
        check("rst_gnt", 32'(gnt_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_flags", 32'(flags_o), 32'(0));
        RST = 1'b0;
        tick();

        // All four requesters held continuously: strict rotation, one grant per 3 cycles.
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3; seq[4] = 3'd0;
        for (int k = 0; k < NREQ; k++) set_cmd(k, OP_CLR, 3'd0, 3'd0, 3'd0, 3'(k));
        req_i = '1;
        for (int i = 0; i < 5; i++) begin
            service(1'b0, 1'b0, w, wt, e);
            check("rotation_winner", 32'(w), 32'(seq[i]));
            check("rotation_spacing", 32'(wt), 32'(1));
        end
        req_i = '0;
        tick();
        tick();
        check("idle_no_gnt", 32'(gnt_o), 32'(0));

        set_flags(8'b0000_0010);
        set_cmd(0, OP_OR, 3'd0, 3'd1, 3'd0, 3'd2);
        req_i[0] = 1'b1;
        service(1'b1, 1'b0, w, wt, e);
        check("or_result", 32'(flags_o), 32'(8'b0000_0110));

        set_flags(8'b0000_1110);
        set_cmd(0, OP_ANDR, 3'd1, 3'd3, 3'd0, 3'd7);
        req_i[0] = 1'b1;
        service(1'b1, 1'b0, w, wt, e);
        check("andr_result", 32'(flags_o), 32'(8'b1000_1110));
        set_cmd(0, OP_ANDR, 3'd3, 3'd1, 3'd0, 3'd7);
        req_i[0] = 1'b1;
        service(1'b1, 1'b0, w, wt, e);
        check("andr_rej_err", 32'(e), 32'(1));
        check("andr_rej_nowrite", 32'(flags_o), 32'(8'b1000_1110));

        set_flags(8'b0000_0101);
        set_cmd(0, OP_MUX, 3'd0, 3'd1, 3'd2, 3'd0);
        req_i[0] = 1'b1;
        service(1'b1, 1'b0, w, wt, e);
        check("mux_result", 32'(flags_o), 32'(8'b0000_0100));
        set_cmd(0, OP_EQ, 3'd4, 3'd4, 3'd0, 3'd4);
        req_i[0] = 1'b1;
        service(1'b1, 1'b0, w, wt, e);
        check("eq_self", 32'(flags_o), 32'(8'b0001_0100));

        // Fields and request altered right after grant must not affect the captured op.
        set_cmd(1, OP_OR, 3'd2, 3'd4, 3'd0, 3'd6);
        req_i[1] = 1'b1;
        service(1'b1, 1'b1, w, wt, e);
        check("perturb_winner", 32'(w), 32'(1));
        check("perturb_result", 32'(flags_o), 32'(8'b0101_0100));
        check("perturb_err", 32'(e), 32'(0));

        // Reset while the command is in EXEC.
        set_cmd(1, OP_NOT, 3'd0, 3'd0, 3'd0, 3'd0);
        req_i[1] = 1'b1;
        n = 0;
        while (gnt_o == '0 && n < 12) begin
            tick();
            n++;
        end
        check("rstmid_gnt", 32'(gnt_o), 32'(4'b0010));
        RST = 1'b1;
        req_i = '0;
        tick();
        check("rstmid_gnt_clr", 32'(gnt_o), 32'(0));
        check("rstmid_done", 32'(done_o), 32'(0));
        check("rstmid_err", 32'(err_o), 32'(0));
        check("rstmid_flags", 32'(flags_o), 32'(0));
        RST = 1'b0;
        mflags = '0;
        mptr   = 0;
        tick();
        check("rstmid_no_late_done", 32'(done_o), 32'(0));
        set_cmd(1, OP_NOT, 3'd0, 3'd0, 3'd0, 3'd0);
        set_cmd(3, OP_NOT, 3'd1, 3'd0, 3'd0, 3'd1);
        req_i = 4'b1010;
        service(1'b1, 1'b0, w, wt, e);
        check("post_rst_ptr0", 32'(w), 32'(1));
        service(1'b1, 1'b0, w, wt, e);
        check("post_rst_second", 32'(w), 32'(3));
        check("post_rst_flags", 32'(flags_o), 32'(8'b0000_0011));

        for (int it = 0; it < 60; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_i[k] && $urandom_range(1, 0) == 1) begin
                    set_cmd(k, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                            3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                            3'($urandom_range(7, 0)));
                    req_i[k] = 1'b1;
                end
            end
            if (req_i == '0) begin
                set_cmd(0, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                        3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                        3'($urandom_range(7, 0)));
                req_i[0] = 1'b1;
            end
            service(1'b1, 1'b0, w, wt, e);
            check("rand_spacing", 32'(wt), 32'(1));
        end

        req_i = '0;
        tick();
        tick();
        check("final_idle", 32'(gnt_o), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitop_sched.md
# bitop_sched

Scheduler sharing one single-bit logic unit and an 8-flag register file among several requesters. Each requester posts a command (logic op, source flag indices, destination flag index). A round-robin arbiter grants one requester at a time. The block executes the op on the current flag values and writes the result back. It is the sequencer for the flag datapath: OR, NOT, equality, mux and AND-reduce updates on single-bit state registers, all clocked on one edge.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- REGS, 8, number of flag bits; IDX_W = clog2(REGS)

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- req_i  in  NREQ  per-requester request level; held until that requester's done_o bit
- op_i  in  3*NREQ  op code, slice k = requester k
- a_i, b_i, c_i  in  IDX_W*NREQ  source flag indices, sliced per requester
- dst_i  in  IDX_W*NREQ  destination flag index
- gnt_o  out  NREQ  one-hot grant, high from capture until writeback
- done_o  out  NREQ  one-cycle completion pulse to the granted requester
- err_o  out  1  one-cycle pulse with done_o when the command was rejected
- flags_o  out  REGS  flag register file

## Operation
- Op codes:
  - 0 OR: a|b
  - 1 NOT: !a
  - 2 EQ: a==b
  - 3 MUX: a?b:c
  - 4 ANDR: &flags[b:a]
  - 5 CLR: 0
  - 6 AND: a&b
  - 7 invalid
- All operands are flag values, read by index.
- ANDR with b<a, or op 7, is rejected: no write, err_o=1 with done_o.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE: if any req_i, pick winner round-robin starting at ptr. Capture its op/a/b/c/dst into command regs. Set gnt_o, set ptr=(winner+1) mod NREQ, go to EXEC. If no request, stay in IDLE.
  - EXEC: compute result from flags_o and the captured command, register it, go to WB.
  - WB: write flags_o[dst] unless rejected. Pulse done_o[winner] and err_o if rejected. Clear gnt_o, go to IDLE.
- Command fields are captured at grant. Changing or dropping req_i/fields after grant does not affect the op in flight.
- A source equal to dst reads the pre-write value.
- Reset: flags_o=0, gnt_o=0, done_o=0, err_o=0, ptr=0, state IDLE. Reset asserted mid-operation aborts the op with no write and no done_o.

## Timing
- Edge 0 (IDLE, req seen): gnt_o visible after edge 0.
- Edge 1: result registered.
- Edge 2: flags_o updated, done_o/err_o high for the following cycle, gnt_o low in the same cycle.
- Throughput: one command per 3 cycles. The earliest next grant is the edge after the done cycle begins, i.e. edge 3.
- A requester must deassert req_i during its done_o cycle, otherwise edge 3 treats it as a new request (legal: back-to-back repeat). Round-robin still favours the others, since ptr has advanced.
- Only one gnt_o/done_o bit is high at any time.

## Structure
- Package bitop_pkg:
  - op code localparams (OP_OR..OP_INV)
  - FSM state encoding (IDLE/EXEC/WB)
  - clog2 helper
- Sub-module rr_arbiter (NREQ): inputs req and ptr, output one-hot winner plus index, combinational. The FSM registers its output.
- The logic unit is a combinational function inside bitop_sched.

## Test plan
- Reset, then requester 0 issues OR a=0 b=1 dst=2 with flags=8'b0000_0010 -> gnt_o=0001 after edge 0, flags_o=8'b0000_0110 and done_o=0001 after edge 2, err_o=0.
- Requesters 0..3 all assert continuously after reset -> grants rotate 0,1,2,3,0, with gnt_o changing every 3 cycles.
- flags=8'b0000_1110, ANDR a=1 b=3 dst=7 -> flags_o[7]=1. Repeat with a=3 b=1 -> no write, err_o pulses with done_o.
- MUX a=0 b=1 c=2 dst=0 with flags=8'b0000_0101 (sel=1, b=0) -> flags_o[0]=0. EQ with a=b=4 dst=4 -> flags_o[4]=1, self-read uses the old value.
- Requester drops req_i and changes op_i one cycle after grant -> the original command completes unchanged.
- RST asserted during EXEC -> no flag write, no done_o, all outputs 0 next cycle. A subsequent request is granted normally with ptr=0.
